uart_tx_fifo_reader: RTL and testbench

UART transmitter that drains the shared synchronous FIFO from its read side. It pops one byte when the FIFO is non-empty, waits for the FIFO's registered read data, and serialises the byte as 8N1 on `txd`, or 8E1 when parity is compiled in. It sits between the write-side producer (CPU peripheral bus path) and the pad.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_timer.sv | 19 +
 rtl/uart_tx_fifo_reader.sv | 105 ++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encoding, frame levels and defaults.
// PARITY_EN reflects the UART_TX_PARITY_EN macro.
package uart_pkg;
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_POP    = 3'd1;
   localparam state_t ST_WAIT   = 3'd2;
   localparam state_t ST_START  = 3'd3;
   localparam state_t ST_DATA   = 3'd4;
   localparam state_t ST_PARITY = 3'd5;
   localparam state_t ST_STOP   = 3'd6;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_BIT  = 1'b1;
   localparam int DEFAULT_DIV_WIDTH = 16;
`ifdef UART_TX_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif
endpackage

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: loadable down-counter; tick marks the last cycle of a bit.
// Reloads from div on every tick so consecutive bits are div+1 cycles long.
module uart_baud_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] div,
   output logic         tick
);
   logic [W-1:0] cnt_q, cnt_d;
   assign tick = cnt_q == '0;
   always_comb cnt_d = (load || tick) ? div : cnt_q - W'(1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: pops bytes from a registered-read FIFO and sends them as 8N1,
// or 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_reader
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIV_WIDTH-1:0]  baud_div,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic                  fifo_rd_valid,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_ready,
   output logic                  txd,
   output logic                  busy
);
   localparam int BW = $clog2(DATA_WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam state_t AFTER_DATA = PARITY_EN ? ST_PARITY : ST_STOP;
   state_t state_q, state_d;
   logic [DATA_WIDTH-1:0] sh_q, sh_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic txd_q, txd_d, busy_q, busy_d, rdy_q, rdy_d;
   logic go, cap, tick, tail_bit;
   assign go  = tx_en && !fifo_empty;
   assign cap = state_q == ST_WAIT && fifo_rd_valid;
   // The divisor is taken live on capture and from the latched copy thereafter
   uart_baud_timer #(.W(DIV_WIDTH)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (cap),
      .div  (cap ? baud_div : div_q),
      .tick (tick)
   );
`ifdef UART_TX_PARITY_EN
   logic par_q, par_d;
   assign par_d = cap ? ^fifo_rd_data : par_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end
   assign tail_bit = state_d == ST_PARITY ? par_q : STOP_BIT;
`else
   assign tail_bit = STOP_BIT;
`endif
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bit_d   = bit_q;
      div_d   = div_q;
      case (state_q)
         ST_IDLE:  state_d = go ? ST_POP : ST_IDLE;
         ST_POP:   state_d = ST_WAIT;
         ST_WAIT:  if (cap) begin
            state_d = ST_START;
            sh_d    = fifo_rd_data;
            div_d   = baud_div;
            bit_d   = '0;
         end
         ST_START: state_d = tick ? ST_DATA : ST_START;
         ST_DATA:  if (tick) begin
            sh_d    = sh_q >> 1;
            bit_d   = bit_q + BW'(1);
            state_d = bit_q == LAST_BIT ? AFTER_DATA : ST_DATA;
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: state_d = tick ? ST_STOP : ST_PARITY;
`endif
         ST_STOP:  state_d = tick ? (go ? ST_POP : ST_IDLE) : ST_STOP;
         default:  state_d = ST_IDLE;
      endcase
   end
   // Outputs are registered from the next state so txd is glitch-free at the pad
   always_comb begin
      txd_d  = state_d == ST_START ? START_BIT : state_d == ST_DATA ? sh_d[0] : tail_bit;
      busy_d = state_d != ST_IDLE;
      rdy_d  = state_d == ST_POP;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sh_q    <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         txd_q   <= IDLE_BIT;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
      end
   end
   assign txd           = txd_q;
   assign busy          = busy_q;
   assign fifo_rd_ready = rdy_q;
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb_uart_tx_fifo_reader: directed frames into a FIFO model; a serial monitor
// checks every bit level and duration against a queue of expected frames.
module tb_uart_tx_fifo_reader;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int NB = 10 + P;
   logic clk = 1'b0, rst, tx_en, fifo_empty, fifo_rd_valid, fifo_rd_ready, txd, busy;
   logic [15:0] baud_div;
   logic [7:0] fifo_rd_data;
   logic [7:0] mem [0:63];
   logic [7:0] ed [0:31];
   int ev [0:31];
   int starts [0:63];
   int wp = 0, rp = 0, ew = 0, er = 0, ns = 0, nf = 0, n_abort = 0;
   int pops = 0, rd_delay = 1, vld_cyc = 0, cyc = 0, n_cmp = 0, n_bad = 0;
   uart_tx_fifo_reader #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .baud_div      (baud_div),
      .tx_en         (tx_en),
      .fifo_empty    (fifo_empty),
      .fifo_rd_valid (fifo_rd_valid),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_ready (fifo_rd_ready),
      .txd           (txd),
      .busy          (busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign fifo_empty = (wp == rp);
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask
   task automatic push(input logic [7:0] d);
      mem[wp] = d;
      wp++;
   endtask
   task automatic expect_frame(input logic [7:0] d);
      ed[ew] = d;
      ev[ew] = int'(baud_div);
      ew++;
   endtask
   task automatic wait_frames(input int n, input string nm);
      int t;
      t = 0;
      while (nf < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk(nm, nf, n);
   endtask
   // FIFO with a registered read: data valid rd_delay cycles after the pop cycle
   initial begin : fifo_model
      logic [7:0] rdat;
      logic prev;
      int vcnt;
      vcnt = 0;
      prev = 1'b0;
      rdat = 8'h00;
      fifo_rd_valid = 1'b0;
      fifo_rd_data = 8'hEE;
      forever begin
         @(negedge clk);
         fifo_rd_valid = 1'b0;
         fifo_rd_data = 8'hEE;
         if (vcnt > 0) begin
            vcnt--;
            if (vcnt == 0) begin
               fifo_rd_valid = 1'b1;
               fifo_rd_data = rdat;
               vld_cyc = cyc;
            end
         end
         if (fifo_rd_ready === 1'b1) begin
            chk("rd_ready single cycle", int'(prev), 0);
            chk("pop from non-empty fifo", int'(wp > rp), 1);
            rdat = mem[rp];
            rp++;
            pops++;
            vcnt = rd_delay;
         end
         prev = fifo_rd_ready;
      end
   end
   initial begin : monitor
      logic [10:0] fb;
      logic got;
      int v;
      bit ab;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || txd !== 1'b0) continue;
         starts[ns] = cyc;
         ns++;
         chk("frame expected", int'(er < ew), 1);
         if (er >= ew) begin
            for (int t = 0; t < 100 && txd === 1'b0; t++) @(negedge clk);
            continue;
         end
         fb = {1'b1, (P != 0) ? ^ed[er] : 1'b1, ed[er], 1'b0};
         v = ev[er];
         er++;
         ab = 1'b0;
         for (int b = 0; b < NB && !ab; b++) begin
            got = fb[b];
            for (int c = 0; c <= v; c++) begin
               if (b != 0 || c != 0) @(negedge clk);
               if (rst) begin
                  ab = 1'b1;
                  break;
               end
               if (txd !== fb[b]) got = txd;
            end
            if (!ab) chk($sformatf("frame %0d bit %0d level", nf, b), int'(got), int'(fb[b]));
         end
         if (ab) n_abort++;
         else nf++;
      end
   end
   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached, got %0d frames", nf);
      $fatal(1);
   end
   initial begin : stimulus
      int c0, s0, bad;
      rst = 1'b1;
      tx_en = 1'b0;
      baud_div = 16'd3;
      repeat (3) @(negedge clk);
      chk("reset txd", int'(txd), 1);
      chk("reset rd_ready", int'(fifo_rd_ready), 0);
      chk("reset busy", int'(busy), 0);
      rst = 1'b0;
      tx_en = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (txd !== 1'b1 || fifo_rd_ready !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("idle with empty fifo", bad, 0);
      // 0xA5 at 4 cycles per bit; the divisor change mid-frame must not affect it
      push(8'hA5);
      expect_frame(8'hA5);
      c0 = cyc;
      s0 = ns;
      @(negedge clk);
      chk("pop ready", int'(fifo_rd_ready), 1);
      chk("busy on pop", int'(busy), 1);
      @(negedge clk);
      chk("ready dropped", int'(fifo_rd_ready), 0);
      chk("txd before start", int'(txd), 1);
      @(negedge clk);
      chk("txd start", int'(txd), 0);
      baud_div = 16'd9;
      wait_frames(1, "A5 frame done");
      chk("A5 start latency", starts[s0] - c0, 3);
      repeat (2) @(negedge clk);
      chk("busy after frame", int'(busy), 0);
      chk("pops after A5", pops, 1);
      // 1-cycle bits; pop and registered read leave two idle-high cycles between frames
      baud_div = 16'd0;
      s0 = ns;
      push(8'h00);
      expect_frame(8'h00);
      push(8'hFF);
      expect_frame(8'hFF);
      wait_frames(3, "00/FF frames done");
      chk("start-to-start 00/FF", starts[s0 + 1] - starts[s0], NB + 2);
      repeat (3) @(negedge clk);
      chk("pops after 00/FF", pops, 3);
      baud_div = 16'd1;
      rd_delay = 5;
      push(8'h5A);
      expect_frame(8'h5A);
      s0 = ns;
      @(negedge clk);
      chk("delayed pop ready", int'(fifo_rd_ready), 1);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b1) bad++;
      end
      chk("hold while waiting for valid", bad, 0);
      @(negedge clk);
      chk("start after late valid", int'(txd), 0);
      wait_frames(4, "5A frame done");
      chk("start one cycle after valid", starts[s0] - vld_cyc, 1);
      rd_delay = 1;
      repeat (2) @(negedge clk);
      push(8'h3C);
      expect_frame(8'h3C);
      push(8'h11);
      push(8'h22);
      repeat (7) @(negedge clk);
      chk("busy during 3C data", int'(busy), 1);
      tx_en = 1'b0;
      wait_frames(5, "3C frame done");
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (txd !== 1'b1 || busy !== 1'b0 || fifo_rd_ready !== 1'b0) bad++;
      end
      chk("idle while disabled", bad, 0);
      chk("pops while disabled", pops, 5);
      expect_frame(8'h11);
      expect_frame(8'h22);
      tx_en = 1'b1;
      wait_frames(7, "11/22 frames done");
      repeat (2) @(negedge clk);
      // 0xE9 has bit 4 low, so an asynchronous return to idle is visible
      baud_div = 16'd3;
      push(8'hE9);
      expect_frame(8'hE9);
      push(8'h4B);
      expect_frame(8'h4B);
      repeat (24) @(negedge clk);
      chk("E9 bit4 low", int'(txd), 0);
      #1 rst = 1'b1;
      #1;
      chk("async reset txd", int'(txd), 1);
      chk("async reset busy", int'(busy), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_frames(8, "4B frame after reset");
      chk("aborted frames", n_abort, 1);
      repeat (3) @(negedge clk);
      chk("total pops", pops, 9);
      chk("expected frames consumed", er, ew);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
